// File: rtl/pcie_rx_req_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rx_req_mc_if
// Brief    : Command-FIFO and TX MRd request buses of the RX read engine.
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_rx_req_mc_if #(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int P_NUM_CH          = 4
);
  logic [P_NUM_CH-1:0]                        cmd_valid;
  logic [P_NUM_CH*(C_PCIE_ADDR_WIDTH-2)-1:0]  cmd_addr;
  logic [P_NUM_CH*11-1:0]                     cmd_len;
  logic [P_NUM_CH-1:0]                        cmd_ready;
  logic                                       tx_dma_mrd_req;
  logic [7:0]                                 tx_dma_mrd_tag;
  logic [10:0]                                tx_dma_mrd_len;
  logic [C_PCIE_ADDR_WIDTH-3:0]               tx_dma_mrd_addr;
  logic                                       tx_dma_mrd_req_ack;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, tx_dma_mrd_req_ack,
    input  cmd_ready, tx_dma_mrd_req, tx_dma_mrd_tag, tx_dma_mrd_len, tx_dma_mrd_addr
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, tx_dma_mrd_req_ack,
    output cmd_ready, tx_dma_mrd_req, tx_dma_mrd_tag, tx_dma_mrd_len, tx_dma_mrd_addr
  );
endinterface
`default_nettype wire

// File: rtl/pcie_rx_req_mc.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rx_req_mc
// Brief    : Round-robin multi-channel MRd request splitter with tag pool.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_rx_req_mc #(
  parameter int C_PCIE_ADDR_WIDTH = 48,
  parameter int P_NUM_CH          = 4,
  parameter int P_TAG_WIDTH       = 5
) (
  input  logic                   pcie_user_clk,
  input  logic                   pcie_user_rst_n,
  input  logic [2:0]             pcie_max_read_req_size,
  pcie_rx_req_mc_if.slave        rq,
  input  logic                   cpld_dma_fifo_wr_en,
  input  logic [7:0]             cpld_dma_fifo_tag,
  input  logic                   cpld_dma_fifo_tag_last,
  output logic [2:0]             cpld_ch,
  output logic                   tag_full_n,
  output logic [P_TAG_WIDTH:0]   tag_outstanding,
  output logic                   tag_err,
  output logic                   busy
);
  localparam int c_aw      = C_PCIE_ADDR_WIDTH - 2;
  localparam int c_num_tag = 2 ** P_TAG_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_REQ = 2'd2} state_t;

  state_t                 r_state;
  logic [2:0]             r_rr_ptr, r_ch, r_code;
  logic [c_aw-1:0]        r_addr, r_tx_addr;
  logic [10:0]            r_rem, r_len;
  logic                   r_req, r_busy, r_full_n, r_err;
  logic [7:0]             r_tag;
  logic [c_num_tag-1:0]   r_alloc;
  logic [2:0]             r_owner [c_num_tag];
  logic [P_TAG_WIDTH:0]   r_outstanding;

  logic [P_NUM_CH-1:0]    w_rot;
  logic [2:0]             w_off, w_grant, w_code, w_rr_nxt;
  logic [3:0]             w_sum;
  logic                   w_grant_vld;
  logic [c_aw-1:0]        w_cmd_addr;
  logic [10:0]            w_cmd_len, w_mrrs_dw, w_room, w_chunk;
  logic                   w_free_vld, w_alloc, w_free_req, w_tag_in_range, w_free, w_bad_free;
  logic [P_TAG_WIDTH-1:0] w_free_idx, w_lookup;
  logic [c_num_tag-1:0]   w_alloc_nxt;

  // Rotate valids so bit 0 is the channel at rr_ptr; lowest set bit wins.
  assign w_rot = P_NUM_CH'({rq.cmd_valid, rq.cmd_valid} >> r_rr_ptr);

  always_comb begin
    w_grant_vld = 1'b0;
    w_off       = '0;
    for (int k = P_NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_grant_vld = 1'b1;
        w_off       = 3'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_grant    = (w_sum >= 4'(P_NUM_CH)) ? 3'(w_sum - 4'(P_NUM_CH)) : w_sum[2:0];
  assign w_rr_nxt   = (w_grant == 3'(P_NUM_CH - 1)) ? 3'd0 : w_grant + 3'd1;
  assign w_cmd_addr = rq.cmd_addr[int'(w_grant)*c_aw +: c_aw];
  assign w_cmd_len  = rq.cmd_len[int'(w_grant)*11 +: 11];
  assign w_code     = (pcie_max_read_req_size > 3'd5) ? 3'd5 : pcie_max_read_req_size;

  assign rq.cmd_ready = (pcie_user_rst_n && r_state == S_IDLE && w_grant_vld)
                        ? (P_NUM_CH'(1) << w_grant) : '0;

  // Chunk ends at the next MRRS-aligned boundary; MRRS divides 4 KB.
  assign w_mrrs_dw = 11'd32 << r_code;
  assign w_room    = w_mrrs_dw - {1'b0, r_addr[9:0] & (w_mrrs_dw[9:0] - 10'd1)};
  assign w_chunk   = (r_rem < w_room) ? r_rem : w_room;

  always_comb begin
    w_free_vld = 1'b0;
    w_free_idx = '0;
    for (int t = c_num_tag - 1; t >= 0; t--) begin
      if (!r_alloc[t]) begin
        w_free_vld = 1'b1;
        w_free_idx = P_TAG_WIDTH'(t);
      end
    end
  end

  assign w_lookup       = cpld_dma_fifo_tag[P_TAG_WIDTH-1:0];
  assign w_tag_in_range = (cpld_dma_fifo_tag >> P_TAG_WIDTH) == 8'd0;
  assign w_free_req     = cpld_dma_fifo_wr_en & cpld_dma_fifo_tag_last;
  assign w_free         = w_free_req & w_tag_in_range & r_alloc[w_lookup];
  assign w_bad_free     = w_free_req & ~(w_tag_in_range & r_alloc[w_lookup]);
  assign w_alloc        = (r_state == S_CALC) & w_free_vld;

  always_comb begin
    w_alloc_nxt = r_alloc;
    if (w_free)  w_alloc_nxt[w_lookup]   = 1'b0;
    if (w_alloc) w_alloc_nxt[w_free_idx] = 1'b1;
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_ch      <= '0;
      r_code    <= '0;
      r_addr    <= '0;
      r_rem     <= '0;
      r_req     <= 1'b0;
      r_tag     <= '0;
      r_len     <= '0;
      r_tx_addr <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_vld) begin
          r_addr   <= w_cmd_addr;
          r_rem    <= (w_cmd_len == 11'd0) ? 11'd1024 : w_cmd_len;
          r_ch     <= w_grant;
          r_code   <= w_code;
          r_rr_ptr <= w_rr_nxt;
          r_busy   <= 1'b1;
          r_state  <= S_CALC;
        end
        S_CALC: if (w_free_vld) begin
          r_tag     <= 8'(w_free_idx);
          r_len     <= w_chunk;
          r_tx_addr <= r_addr;
          r_req     <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: if (rq.tx_dma_mrd_req_ack) begin
          r_req  <= 1'b0;
          r_addr <= r_addr + c_aw'(r_len);
          r_rem  <= r_rem - r_len;
          if (r_rem == r_len) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CALC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      r_alloc       <= '0;
      r_full_n      <= 1'b1;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      for (int t = 0; t < c_num_tag; t++) r_owner[t] <= '0;
    end else begin
      r_alloc  <= w_alloc_nxt;
      r_full_n <= ~&w_alloc_nxt;
      if (w_alloc) r_owner[w_free_idx] <= r_ch;
      if (w_bad_free) r_err <= 1'b1;
      case ({w_alloc, w_free})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign rq.tx_dma_mrd_req  = r_req;
  assign rq.tx_dma_mrd_tag  = r_tag;
  assign rq.tx_dma_mrd_len  = r_len;
  assign rq.tx_dma_mrd_addr = r_tx_addr;
  assign cpld_ch            = r_owner[w_lookup];
  assign tag_full_n         = r_full_n;
  assign tag_outstanding    = r_outstanding;
  assign tag_err            = r_err;
  assign busy               = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_pcie_rx_req_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_rx_req_mc
// Brief    : Random + directed bench with a chunk-list / tag-set reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_rx_req_mc;
  localparam int AW = 46, NCH = 4, TW = 5, NTAG = 32;

  typedef struct { logic [AW-1:0] addr; logic [10:0] len; } cmd_t;
  typedef struct { logic [AW-1:0] addr; logic [10:0] len; int ch; } chunk_t;
  typedef struct { logic [AW-1:0] addr; logic [10:0] len; logic [7:0] tag; } issue_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] mrrs = '0;
  logic wr_en = 1'b0, tag_last = 1'b0;
  logic [7:0] cpl_tag = '0;
  logic [2:0] cpld_ch;
  logic tag_full_n, tag_err, busy;
  logic [TW:0] tag_outstanding;

  pcie_rx_req_mc_if #(.C_PCIE_ADDR_WIDTH(48), .P_NUM_CH(NCH)) bus ();

  pcie_rx_req_mc #(.C_PCIE_ADDR_WIDTH(48), .P_NUM_CH(NCH), .P_TAG_WIDTH(TW)) dut (
    .pcie_user_clk(clk), .pcie_user_rst_n(rst_n), .pcie_max_read_req_size(mrrs),
    .rq(bus), .cpld_dma_fifo_wr_en(wr_en), .cpld_dma_fifo_tag(cpl_tag),
    .cpld_dma_fifo_tag_last(tag_last), .cpld_ch(cpld_ch), .tag_full_n(tag_full_n),
    .tag_outstanding(tag_outstanding), .tag_err(tag_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  cmd_t   ch_q [NCH][$];
  chunk_t exp_q[$];
  issue_t issue_log[$];
  int     grant_log[$];
  bit     m_alloc [NTAG];
  int     m_owner [NTAG];
  int     m_rr, cur_tag, calc_cycles, code_now, ack_pct, free_pct;
  bit     m_err, pend_ack, prev_req;
  int     pend_hs_ch = -1, pend_code, pend_free = -1, force_free = -1;
  cmd_t   pend_cmd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int t = 0; t < NTAG; t++) if (!m_alloc[t]) return t;
    return -1;
  endfunction

  function automatic int pop_cnt();
    int n = 0;
    for (int t = 0; t < NTAG; t++) n += int'(m_alloc[t]);
    return n;
  endfunction

  function automatic int pick_alloc();
    int n = pop_cnt(), k;
    if (n == 0) return -1;
    k = $urandom_range(n - 1);
    for (int t = 0; t < NTAG; t++) if (m_alloc[t]) begin
      if (k == 0) return t;
      k--;
    end
    return -1;
  endfunction

  // Expected request list: cut at every MRRS-aligned boundary.
  function automatic void push_chunks(int ch, logic [AW-1:0] a, logic [10:0] l, int code);
    int rem = (l == 0) ? 1024 : int'(l);
    int mrrs_dw = 32 << ((code > 5) ? 5 : code);
    logic [AW-1:0] addr = a;
    chunk_t c;
    while (rem > 0) begin
      int room = mrrs_dw - (int'(addr[9:0]) % mrrs_dw);
      int n = (rem < room) ? rem : room;
      c.addr = addr; c.len = 11'(n); c.ch = ch;
      exp_q.push_back(c);
      addr = addr + AW'(n);
      rem -= n;
    end
  endfunction

  function automatic bit engine_idle();
    bit e = (exp_q.size() == 0) && (pend_hs_ch < 0) && !pend_ack && !bus.tx_dma_mrd_req;
    for (int c = 0; c < NCH; c++) if (ch_q[c].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic reset_model();
    exp_q.delete(); grant_log.delete(); issue_log.delete();
    for (int c = 0; c < NCH; c++) ch_q[c].delete();
    for (int t = 0; t < NTAG; t++) begin m_alloc[t] = 1'b0; m_owner[t] = 0; end
    m_rr = 0; m_err = 1'b0; pend_ack = 1'b0; prev_req = 1'b0;
    pend_hs_ch = -1; pend_free = -1; force_free = -1; calc_cycles = 0;
  endtask

  task automatic push_cmd(input int ch, input logic [AW-1:0] a, input logic [10:0] l);
    cmd_t c;
    c.addr = a; c.len = l;
    ch_q[ch].push_back(c);
  endtask

  task automatic step();
    int lf, g, n;
    bit ackw, newreq, pfv;
    logic [NCH-1:0] vm, expr;
    logic [7:0] ft;
    @(negedge clk);
    ackw = pend_ack;
    if (pend_hs_ch >= 0) begin
      push_chunks(pend_hs_ch, pend_cmd.addr, pend_cmd.len, pend_code);
      grant_log.push_back(pend_hs_ch);
      m_rr = (pend_hs_ch + 1) % NCH; pend_hs_ch = -1; calc_cycles = 0;
    end
    if (pend_ack) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pend_ack = 1'b0; calc_cycles = 0;
    end
    lf  = lowest_free();
    pfv = (pend_free >= 0 && pend_free < NTAG) ? m_alloc[pend_free] : 1'b0;
    newreq = bus.tx_dma_mrd_req && (!prev_req || ackw);
    if (bus.tx_dma_mrd_req) begin
      if (exp_q.size() == 0) check("req_spurious", 64'(bus.tx_dma_mrd_req), 0);
      else begin
        if (newreq) begin
          check("req_early", 64'(calc_cycles >= 1), 1);
          check("req_tag", bus.tx_dma_mrd_tag, (lf < 0) ? 64'hff : 64'(lf));
          cur_tag = lf;
          if (lf >= 0) begin m_alloc[lf] = 1'b1; m_owner[lf] = exp_q[0].ch; end
          issue_log.push_back('{bus.tx_dma_mrd_addr, bus.tx_dma_mrd_len, bus.tx_dma_mrd_tag});
        end else check("req_tag_hold", bus.tx_dma_mrd_tag, 64'(cur_tag));
        check("req_addr", bus.tx_dma_mrd_addr, exp_q[0].addr);
        check("req_len", bus.tx_dma_mrd_len, exp_q[0].len);
      end
    end else if (exp_q.size() > 0) begin
      if (calc_cycles >= 1 && lf >= 0) check("req_latency", 64'(bus.tx_dma_mrd_req), 1);
      calc_cycles++;
    end
    if (pend_free >= 0) begin
      if (pfv) m_alloc[pend_free] = 1'b0; else m_err = 1'b1;
      pend_free = -1;
    end
    n = pop_cnt();
    check("tag_outstanding", tag_outstanding, 64'(n));
    check("tag_full_n", tag_full_n, 64'(n < NTAG));
    check("tag_err", tag_err, m_err);
    check("busy", busy, 64'(exp_q.size() > 0));
    prev_req = bus.tx_dma_mrd_req;

    bus.tx_dma_mrd_req_ack = 1'b0;
    if (bus.tx_dma_mrd_req && $urandom_range(99) < ack_pct) begin
      bus.tx_dma_mrd_req_ack = 1'b1; pend_ack = 1'b1;
    end
    wr_en = 1'b0; tag_last = 1'b0;
    if (force_free >= 0) begin
      ft = 8'(force_free); wr_en = 1'b1; tag_last = 1'b1; pend_free = force_free; force_free = -1;
    end else begin
      g = pick_alloc();
      if (g >= 0) begin
        ft = 8'(g);
        if ($urandom_range(99) < free_pct) begin wr_en = 1'b1; tag_last = 1'b1; pend_free = g; end
        else if ($urandom_range(3) == 0) wr_en = 1'b1;
      end else ft = 8'($urandom_range(NTAG - 1));
    end
    cpl_tag = ft;
    for (int c = 0; c < NCH; c++) begin
      vm[c] = ch_q[c].size() > 0;
      bus.cmd_addr[c*AW +: AW] = vm[c] ? ch_q[c][0].addr : '0;
      bus.cmd_len[c*11 +: 11]  = vm[c] ? ch_q[c][0].len : '0;
    end
    bus.cmd_valid = vm;
    mrrs = 3'(code_now);
    #1;
    if (int'(ft) < NTAG && m_alloc[ft[TW-1:0]]) check("cpld_ch", cpld_ch, 64'(m_owner[ft[TW-1:0]]));
    expr = '0; g = -1;
    if (exp_q.size() == 0)
      for (int k = NCH - 1; k >= 0; k--) if (vm[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
    if (g >= 0) expr[g] = 1'b1;
    check("cmd_ready", bus.cmd_ready, expr);
    if (g >= 0) begin pend_hs_ch = g; pend_cmd = ch_q[g].pop_front(); pend_code = code_now; end
  endtask

  task automatic drain(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin step(); done = engine_idle(); end
    check("drain_done", 64'(done), 1);
  endtask

  task automatic free_all();
    bit done = 1'b0;
    int sv = free_pct;
    free_pct = 100;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(); done = engine_idle() && pop_cnt() == 0 && pend_free < 0;
    end
    check("free_all_done", 64'(done), 1);
    free_pct = sv;
  endtask

  initial begin
    int base;
    reset_model();
    bus.cmd_valid = 4'b0001; bus.cmd_addr = '0; bus.cmd_len = '0; bus.tx_dma_mrd_req_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_req", bus.tx_dma_mrd_req, 0);
    check("rst_tag", bus.tx_dma_mrd_tag, 0);
    check("rst_len", bus.tx_dma_mrd_len, 0);
    check("rst_addr", bus.tx_dma_mrd_addr, 0);
    check("rst_full_n", tag_full_n, 1);
    check("rst_outstanding", tag_outstanding, 0);
    check("rst_err", tag_err, 0);
    check("rst_busy", busy, 0);
    bus.cmd_valid = '0;
    rst_n = 1'b1;

    // Split at a 64 DW boundary, then 1024 DW MRRS from an out-of-range code.
    ack_pct = 50; free_pct = 0; code_now = 1;
    push_cmd(0, 46'h3F0, 11'd100);
    drain(500);
    check("t1_grants", 64'(grant_log.size()), 1);
    check("t1_nreq", 64'(issue_log.size()), 3);
    if (issue_log.size() == 3) begin
      check("t1_r0", {issue_log[0].addr, issue_log[0].len, issue_log[0].tag}, {46'h3F0, 11'd16, 8'd0});
      check("t1_r1", {issue_log[1].addr, issue_log[1].len, issue_log[1].tag}, {46'h400, 11'd64, 8'd1});
      check("t1_r2", {issue_log[2].addr, issue_log[2].len, issue_log[2].tag}, {46'h440, 11'd20, 8'd2});
    end
    code_now = 7; base = issue_log.size();
    push_cmd(0, 46'h3C0, 11'd128);
    drain(500);
    check("t2_nreq", 64'(issue_log.size() - base), 2);
    if (issue_log.size() == base + 2) begin
      check("t2_r0", {issue_log[base].addr, issue_log[base].len}, {46'h3C0, 11'd64});
      check("t2_r1", {issue_log[base+1].addr, issue_log[base+1].len}, {46'h400, 11'd64});
    end

    // Round robin with ch0 joining late.
    code_now = 0; base = grant_log.size();
    for (int c = 1; c < NCH; c++) begin push_cmd(c, 46'(c * 'h100), 11'd4); push_cmd(c, 46'(c * 'h100 + 8), 11'd4); end
    for (int i = 0; i < 2000 && !engine_idle(); i++) begin
      step();
      if (grant_log.size() == base + 4 && ch_q[0].size() == 0 && pend_hs_ch != 0) push_cmd(0, 46'h20, 11'd4);
    end
    check("t3_ngrant", 64'(grant_log.size() - base), 7);
    if (grant_log.size() == base + 7) begin
      int exp_order[7] = '{1, 2, 3, 1, 2, 3, 0};
      for (int i = 0; i < 7; i++) check("t3_order", 64'(grant_log[base + i]), 64'(exp_order[i]));
    end
    free_all();

    // Tag pool exhaustion and reuse of a freed tag.
    free_pct = 0; ack_pct = 100; base = issue_log.size();
    for (int i = 0; i < 33; i++) push_cmd(2, 46'(i * 'h40), 11'd1);
    repeat (300) step();
    check("t4_outstanding", tag_outstanding, 32);
    check("t4_full_n", tag_full_n, 0);
    check("t4_busy", busy, 1);
    check("t4_req_idle", bus.tx_dma_mrd_req, 0);
    check("t4_nreq", 64'(issue_log.size() - base), 32);
    for (int i = 0; i < 32 && base + i < issue_log.size(); i++) check("t4_tag_seq", issue_log[base + i].tag, 64'(i));
    base = issue_log.size(); force_free = 7;
    for (int i = 0; i < 20 && issue_log.size() == base; i++) step();
    check("t4_reuse_seen", 64'(issue_log.size() - base), 1);
    if (issue_log.size() > base) check("t4_reuse_tag", issue_log[base].tag, 7);
    free_all();

    // Bad frees set a sticky error and leave the pool alone.
    force_free = 3; step(); step();
    check("t5_err", tag_err, 1);
    force_free = 200; repeat (6) step();
    check("t5_err_sticky", tag_err, 1);
    check("t5_outstanding", tag_outstanding, 0);
    free_pct = 15; ack_pct = 60;
    push_cmd(1, 46'h1000, 11'd300); push_cmd(3, 46'h2FF0, 11'd90);
    drain(3000);

    // Asynchronous reset with a request pending.
    ack_pct = 0; free_pct = 0;
    push_cmd(1, 46'h5000, 11'd200);
    for (int i = 0; i < 50 && !bus.tx_dma_mrd_req; i++) step();
    check("t6_req_before", bus.tx_dma_mrd_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req", bus.tx_dma_mrd_req, 0);
    check("t6_busy", busy, 0);
    check("t6_outstanding", tag_outstanding, 0);
    check("t6_ready", bus.cmd_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = '0; bus.tx_dma_mrd_req_ack = 1'b0; wr_en = 1'b0; tag_last = 1'b0;
    reset_model();
    rst_n = 1'b1;
    ack_pct = 70; free_pct = 30;
    for (int c = NCH - 1; c >= 0; c--) push_cmd(c, 46'(c * 'h77), 11'd5);
    drain(1000);
    check("t6_first_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hff, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(19) == 0) code_now = $urandom_range(7);
      for (int c = 0; c < NCH; c++)
        if (ch_q[c].size() == 0 && $urandom_range(99) < 30)
          push_cmd(c, AW'({$urandom, $urandom}),
                   ($urandom_range(7) == 0) ? 11'($urandom_range(1024)) : 11'($urandom_range(1, 64)));
      step();
    end
    drain(20000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pcie_rx_req_mc.md
# pcie_rx_req_mc

Multi-channel PCIe memory-read request engine for the RX DMA path. Arbitrates read commands from P_NUM_CH DMA channels round-robin and splits each into MRd requests that respect Max Read Request Size and 4 KB boundaries. Allocates tags from a parametrised pool and tracks each tag's owning channel. Frees each tag on its final completion. Sits between the per-channel RX command FIFOs and the TX MRd request port.

## Interface
- C_PCIE_ADDR_WIDTH, 48, PCIe address width in bytes; addresses carried as dword address [C_PCIE_ADDR_WIDTH-1:2]
- P_NUM_CH, 4, number of command channels (1..8)
- P_TAG_WIDTH, 5, log2 of tag pool size (1..8); P_NUM_TAG = 2**P_TAG_WIDTH
- pcie_user_clk  in  1  sole clock
- pcie_user_rst_n  in  1  asynchronous, active-low reset
- pcie_max_read_req_size  in  3  MRRS code: 0=128 B … 5=4096 B; codes 6,7 treated as 5
- cmd_valid  in  P_NUM_CH  per-channel command valid
- cmd_addr  in  P_NUM_CH*(C_PCIE_ADDR_WIDTH-2)  per-channel start dword address; channel i at slice i
- cmd_len  in  P_NUM_CH*11  per-channel length in dwords; legal 1..1024
- cmd_ready  out  P_NUM_CH  one-hot accept; handshake = valid & ready
- tx_dma_mrd_req  out  1  request valid
- tx_dma_mrd_tag  out  8  tag, zero-extended from P_TAG_WIDTH bits
- tx_dma_mrd_len  out  11  chunk length in dwords
- tx_dma_mrd_addr  out  C_PCIE_ADDR_WIDTH-2  chunk dword address
- tx_dma_mrd_req_ack  in  1  request consumed
- cpld_dma_fifo_wr_en  in  1  completion data beat
- cpld_dma_fifo_tag  in  8  tag of the beat
- cpld_dma_fifo_tag_last  in  1  beat completes the tag
- cpld_ch  out  3  owning channel of cpld_dma_fifo_tag (combinational lookup)
- tag_full_n  out  1  at least one tag free
- tag_outstanding  out  P_TAG_WIDTH+1  allocated tag count
- tag_err  out  1  sticky: free of an unallocated or out-of-range tag
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, CALC, REQ.
- IDLE
  - Grant g = first valid channel at or after rr_ptr (wrapping).
  - cmd_ready[g]=1 combinationally.
  - On handshake: latch addr, rem=len, channel g and MRRS code; rr_ptr←g+1 mod P_NUM_CH; go to CALC.
- CALC
  - mrrs_dw = 32<<min(code,5).
  - chunk = min(rem, mrrs_dw − (addr mod mrrs_dw)). MRRS is a power of two ≤1024 DW, so a chunk never crosses 4 KB.
  - If tag_full_n: allocate the lowest-index free tag, record owner=g, register chunk/addr/tag, set tx_dma_mrd_req, go to REQ.
  - Otherwise stay in CALC.
- REQ
  - tag, len and addr are held stable while req=1.
  - On ack: req←0, addr+=chunk, rem−=chunk.
  - If rem==0 go to IDLE, else go to CALC.
- Tag free: when cpld_dma_fifo_wr_en & cpld_dma_fifo_tag_last and the tag is allocated, clear its bit; it is reusable from the next cycle.
  - Free of an unallocated tag, or tag ≥ P_NUM_TAG: ignored, tag_err←1.
- Same-cycle alloc and free: both apply. The freed tag is never the one allocated in that cycle, because allocation only picks tags free at the clock edge.
- tag_outstanding = popcount of the allocation vector, updated by +1, −1, or 0 on simultaneous alloc and free.
- cmd_len=0 is illegal; the block treats it as 1024.

## Timing
- Reset (async assert): state=IDLE, rr_ptr=0, allocation vector=0, tx_dma_mrd_req=0, tag/len/addr=0, tag_full_n=1, tag_outstanding=0, tag_err=0, busy=0.
  - cmd_ready=0 while reset is asserted.
  - Reset mid-request drops req with no completion of the pending command.
- Latency: handshake at cycle T → tx_dma_mrd_req=1 at T+2 when a tag is free.
  - Ack at cycle A → next chunk's req at A+2.
  - After the final ack, the earliest next cmd_ready is at A+1.
- All outputs are registered except cmd_ready and cpld_ch.
- tag_full_n and tag_outstanding reflect the allocation vector in the same cycle it updates.
- MRRS changes affect only commands accepted afterwards.

## Test plan
- MRRS=1 (64 DW), ch0 addr 0x3F0 DW, len 100 → 3 requests: (0x3F0, 16, tag0), (0x400, 64, tag1), (0x440, 20, tag2); cmd_ready[0] pulses once.
- MRRS=7 (treated as 4096 B), addr 0x3C0 DW, len 128 → (0x3C0, 64) and (0x400, 64); no request crosses 4 KB.
- ch1, ch2, ch3 valid continuously with rr_ptr=0 → accept order ch1, ch2, ch3, ch1; ch0 is later inserted after the current grant.
- P_TAG_WIDTH=5, 33 single-chunk commands, no completions → tags 0..31 issued, tag_full_n=0, tag_outstanding=32, FSM holds in CALC. Free tag 7 → next request carries tag 7 two cycles later.
- Completion of tag 3 with tag_last while tag 3 is unallocated → tag_err=1 and stays 1; allocation unchanged. cpld_ch matches the owning channel for allocated tags.
- Reset asserted while req=1 → req, busy and tag_outstanding go to 0 immediately. After release, a new command is accepted from channel 0 first.
